// File: rtl/reg_to_obi_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : reg_to_obi_bridge
//  Purpose  : Bridges a register-interface initiator onto an OBI master port.
//             One transaction is outstanding at a time. A response watchdog
//             completes the reg side with an error if the OBI slave never
//             answers. The late response is then drained before the next
//             request is accepted.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i, rst_i          clock, synchronous active-high reset
//    reg_valid_i           reg request valid, held until reg_ready_o
//    reg_write_i           1 = write, 0 = read
//    reg_addr_i            byte address
//    reg_wdata_i           write data
//    reg_wstrb_i           byte strobes
//    reg_ready_o           one-cycle completion pulse
//    reg_rdata_o           read data, valid with reg_ready_o
//    reg_error_o           error flag, valid with reg_ready_o
//    obi_req_o             OBI request
//    obi_addr_o            word-aligned OBI address
//    obi_we_o              OBI write enable
//    obi_be_o              OBI byte enables
//    obi_wdata_o           OBI write data
//    obi_gnt_i             OBI grant
//    obi_rvalid_i          OBI response valid
//    obi_rdata_i           OBI read data
//    timeout_o             one-cycle pulse when the watchdog fires
//    timeout_count_o       saturating count of watchdog events
// ============================================================================
module reg_to_obi_bridge #(
    parameter int unsigned AW             = 32,
    parameter int unsigned DW             = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    // reg-bus side
    input  logic              reg_valid_i,
    input  logic              reg_write_i,
    input  logic [AW-1:0]     reg_addr_i,
    input  logic [DW-1:0]     reg_wdata_i,
    input  logic [DW/8-1:0]   reg_wstrb_i,
    output logic              reg_ready_o,
    output logic [DW-1:0]     reg_rdata_o,
    output logic              reg_error_o,
    // OBI master side
    output logic              obi_req_o,
    output logic [AW-1:0]     obi_addr_o,
    output logic              obi_we_o,
    output logic [DW/8-1:0]   obi_be_o,
    output logic [DW-1:0]     obi_wdata_o,
    input  logic              obi_gnt_i,
    input  logic              obi_rvalid_i,
    input  logic [DW-1:0]     obi_rdata_i,
    // watchdog status
    output logic              timeout_o,
    output logic [7:0]        timeout_count_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int unsigned c_SW        = DW / 8;
    // The counter only has to reach TIMEOUT_CYCLES-1.
    localparam int unsigned c_CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned c_LIMIT     = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [c_CNT_W-1:0] c_LIMIT_CNT = c_CNT_W'(c_LIMIT);
    localparam bit          c_WDOG_EN   = (TIMEOUT_CYCLES != 0);
    // Clears the two byte-offset bits so the OBI address is word aligned.
    localparam logic [AW-1:0] c_ADDR_MASK = ~AW'(3);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_RESP  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------------
    state_t             r_state,         w_state;
    logic               r_obi_req,       w_obi_req;
    logic [AW-1:0]      r_obi_addr,      w_obi_addr;
    logic               r_obi_we,        w_obi_we;
    logic [c_SW-1:0]    r_obi_be,        w_obi_be;
    logic [DW-1:0]      r_obi_wdata,     w_obi_wdata;
    logic               r_reg_ready,     w_reg_ready;
    logic [DW-1:0]      r_reg_rdata,     w_reg_rdata;
    logic               r_reg_error,     w_reg_error;
    logic               r_timeout,       w_timeout;
    logic [7:0]         r_timeout_count, w_timeout_count;
    logic [c_CNT_W-1:0] r_cnt,           w_cnt;
    logic               r_drain,         w_drain;

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state         <= S_IDLE;
            r_obi_req       <= 1'b0;
            r_obi_addr      <= '0;
            r_obi_we        <= 1'b0;
            r_obi_be        <= '0;
            r_obi_wdata     <= '0;
            r_reg_ready     <= 1'b0;
            r_reg_rdata     <= '0;
            r_reg_error     <= 1'b0;
            r_timeout       <= 1'b0;
            r_timeout_count <= 8'd0;
            r_cnt           <= '0;
            r_drain         <= 1'b0;
        end else begin
            r_state         <= w_state;
            r_obi_req       <= w_obi_req;
            r_obi_addr      <= w_obi_addr;
            r_obi_we        <= w_obi_we;
            r_obi_be        <= w_obi_be;
            r_obi_wdata     <= w_obi_wdata;
            r_reg_ready     <= w_reg_ready;
            r_reg_rdata     <= w_reg_rdata;
            r_reg_error     <= w_reg_error;
            r_timeout       <= w_timeout;
            r_timeout_count <= w_timeout_count;
            r_cnt           <= w_cnt;
            r_drain         <= w_drain;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        // Everything holds by default; the completion and timeout strobes
        // are single-cycle pulses and default low.
        w_state         = r_state;
        w_obi_req       = r_obi_req;
        w_obi_addr      = r_obi_addr;
        w_obi_we        = r_obi_we;
        w_obi_be        = r_obi_be;
        w_obi_wdata     = r_obi_wdata;
        w_reg_ready     = 1'b0;
        w_reg_rdata     = r_reg_rdata;
        w_reg_error     = r_reg_error;
        w_timeout       = 1'b0;
        w_timeout_count = r_timeout_count;
        w_cnt           = r_cnt;
        w_drain         = r_drain;

        case (r_state)
            S_IDLE: begin
                // Reg inputs are sampled only here; the OBI payload is then
                // frozen for the rest of the transaction.
                if (reg_valid_i) begin
                    w_obi_addr  = reg_addr_i & c_ADDR_MASK;
                    w_obi_we    = reg_write_i;
                    w_obi_wdata = reg_wdata_i;
                    w_obi_be    = reg_write_i ? reg_wstrb_i : {c_SW{1'b1}};
                    w_obi_req   = 1'b1;
                    w_state     = S_REQ;
                end
            end

            S_REQ: begin
                // A request cannot be withdrawn once raised, so there is no
                // watchdog here. A stray rvalid before the grant is ignored.
                if (obi_gnt_i) begin
                    w_obi_req = 1'b0;
                    w_cnt     = '0;
                    w_state   = S_RESP;
                end
            end

            S_RESP: begin
                // rvalid is tested first so that a response arriving in the
                // expiry cycle still completes without error.
                if (obi_rvalid_i) begin
                    w_reg_rdata = r_obi_we ? '0 : obi_rdata_i;
                    w_reg_error = 1'b0;
                    w_reg_ready = 1'b1;
                    w_state     = S_DONE;
                end else if (c_WDOG_EN && (r_cnt == c_LIMIT_CNT)) begin
                    w_reg_rdata = '0;
                    w_reg_error = 1'b1;
                    w_reg_ready = 1'b1;
                    w_timeout   = 1'b1;
                    w_drain     = 1'b1;
                    if (r_timeout_count != 8'hFF) begin
                        w_timeout_count = r_timeout_count + 8'd1;
                    end
                    w_state     = S_DONE;
                end else if (c_WDOG_EN) begin
                    w_cnt = r_cnt + 1'b1;
                end
            end

            S_DONE: begin
                // reg_ready_o is high for this single cycle.
                w_state = r_drain ? S_DRAIN : S_IDLE;
            end

            S_DRAIN: begin
                // The slave still owes us a response for the abandoned
                // transaction; swallow it before accepting new work.
                if (obi_rvalid_i) begin
                    w_drain = 1'b0;
                    w_state = S_IDLE;
                end
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------------
    assign obi_req_o       = r_obi_req;
    assign obi_addr_o      = r_obi_addr;
    assign obi_we_o        = r_obi_we;
    assign obi_be_o        = r_obi_be;
    assign obi_wdata_o     = r_obi_wdata;
    assign reg_ready_o     = r_reg_ready;
    assign reg_rdata_o     = r_reg_rdata;
    assign reg_error_o     = r_reg_error;
    assign timeout_o       = r_timeout;
    assign timeout_count_o = r_timeout_count;

endmodule
`default_nettype wire

// File: tb/tb_reg_to_obi_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_to_obi_bridge
//  Purpose  : Self-checking bench for reg_to_obi_bridge. One instance runs
//             with an 8-cycle watchdog, a second with the watchdog disabled.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_to_obi_bridge;

    logic        clk;
    logic        rst;

    // Instance with TIMEOUT_CYCLES = 8
    logic        reg_valid, reg_write;
    logic [31:0] reg_addr, reg_wdata;
    logic [3:0]  reg_wstrb;
    logic        reg_ready, reg_error;
    logic [31:0] reg_rdata;
    logic        obi_req, obi_we;
    logic [31:0] obi_addr, obi_wdata;
    logic [3:0]  obi_be;
    logic        obi_gnt, obi_rvalid;
    logic [31:0] obi_rdata;
    logic        timeout;
    logic [7:0]  tcount;

    // Instance with TIMEOUT_CYCLES = 0
    logic        z_valid, z_write;
    logic [31:0] z_addr, z_wdata;
    logic [3:0]  z_wstrb;
    logic        z_ready, z_error;
    logic [31:0] z_rdata;
    logic        z_req, z_we;
    logic [31:0] z_obi_addr, z_obi_wdata;
    logic [3:0]  z_be;
    logic        z_gnt, z_rvalid;
    logic [31:0] z_obi_rdata;
    logic        z_timeout;
    logic [7:0]  z_tcount;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [7:0] exp_tc = 8'd0;

    reg_to_obi_bridge #(.AW(32), .DW(32), .TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .reg_valid_i(reg_valid), .reg_write_i(reg_write), .reg_addr_i(reg_addr),
        .reg_wdata_i(reg_wdata), .reg_wstrb_i(reg_wstrb),
        .reg_ready_o(reg_ready), .reg_rdata_o(reg_rdata), .reg_error_o(reg_error),
        .obi_req_o(obi_req), .obi_addr_o(obi_addr), .obi_we_o(obi_we),
        .obi_be_o(obi_be), .obi_wdata_o(obi_wdata),
        .obi_gnt_i(obi_gnt), .obi_rvalid_i(obi_rvalid), .obi_rdata_i(obi_rdata),
        .timeout_o(timeout), .timeout_count_o(tcount)
    );

    reg_to_obi_bridge #(.AW(32), .DW(32), .TIMEOUT_CYCLES(0)) dut_nowd (
        .clk_i(clk), .rst_i(rst),
        .reg_valid_i(z_valid), .reg_write_i(z_write), .reg_addr_i(z_addr),
        .reg_wdata_i(z_wdata), .reg_wstrb_i(z_wstrb),
        .reg_ready_o(z_ready), .reg_rdata_o(z_rdata), .reg_error_o(z_error),
        .obi_req_o(z_req), .obi_addr_o(z_obi_addr), .obi_we_o(z_we),
        .obi_be_o(z_be), .obi_wdata_o(z_obi_wdata),
        .obi_gnt_i(z_gnt), .obi_rvalid_i(z_rvalid), .obi_rdata_i(z_obi_rdata),
        .timeout_o(z_timeout), .timeout_count_o(z_tcount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish within its time budget");
        $fatal(1, "global timeout");
    end

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          gnt_dly;   // REQ cycles without grant
        int          rv_dly;    // RESP cycles without rvalid
        logic [31:0] rdata;     // OBI read data presented with rvalid
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_rdata;
        logic        e_err;
        int          e_lat;     // cycles from valid to ready, inclusive
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one transaction on the watchdog instance and checks it end to end.
    task automatic run_txn(input vec_t v, input string tag);
        int lat;
        lat        = 0;
        reg_valid  = 1'b1;
        reg_write  = v.write;
        reg_addr   = v.addr;
        reg_wdata  = v.wdata;
        reg_wstrb  = v.wstrb;
        for (int c = 1; c <= 40; c++) begin
            tick();
            obi_gnt    = 1'b0;
            obi_rvalid = 1'b0;
            obi_rdata  = 32'hBAD0_BAD0;
            if (reg_ready) begin
                lat = c + 1;
                break;
            end
            if (c == 1) begin
                check({tag, "_req"},   32'(obi_req), 32'd1);
                check({tag, "_addr"},  obi_addr, v.e_addr);
                check({tag, "_be"},    32'(obi_be), 32'(v.e_be));
                check({tag, "_we"},    32'(obi_we), 32'(v.write));
                check({tag, "_wdata"}, obi_wdata, v.wdata);
                // Later input changes must not disturb the transaction.
                reg_addr  = ~v.addr;
                reg_wdata = ~v.wdata;
                reg_wstrb = ~v.wstrb;
                reg_write = ~v.write;
            end
            if (c == 1 + v.gnt_dly) begin
                check({tag, "_req_at_gnt"},  32'(obi_req), 32'd1);
                check({tag, "_addr_at_gnt"}, obi_addr, v.e_addr);
                obi_gnt = 1'b1;
            end
            if (c == 2 + v.gnt_dly) begin
                check({tag, "_req_dropped"}, 32'(obi_req), 32'd0);
            end
            if (c == 2 + v.gnt_dly + v.rv_dly) begin
                obi_rvalid = 1'b1;
                obi_rdata  = v.rdata;
            end
        end
        check({tag, "_latency"}, 32'(lat), 32'(v.e_lat));
        check({tag, "_rdata"},   reg_rdata, v.e_rdata);
        check({tag, "_error"},   32'(reg_error), 32'(v.e_err));
        check({tag, "_no_to"},   32'(timeout), 32'd0);
        check({tag, "_tcount"},  32'(tcount), 32'(exp_tc));
        reg_valid = 1'b0;
        tick();
        check({tag, "_ready_1cyc"}, 32'(reg_ready), 32'd0);
        check({tag, "_rdata_hold"}, reg_rdata, v.e_rdata);
    endtask

    // Forces one watchdog expiry and then drains the late response.
    task automatic force_timeout();
        int lat;
        lat       = 0;
        reg_valid = 1'b1;
        reg_write = 1'b1;
        reg_addr  = 32'h44;
        reg_wdata = 32'h1;
        reg_wstrb = 4'hF;
        for (int c = 1; c <= 30; c++) begin
            tick();
            obi_gnt    = 1'b0;
            obi_rvalid = 1'b0;
            if (reg_ready) begin
                lat = c;
                break;
            end
            if (c == 1) obi_gnt = 1'b1;
        end
        reg_valid = 1'b0;
        check("sat_expiry_cycle", 32'(lat), 32'd10);
        if (exp_tc != 8'hFF) exp_tc = exp_tc + 8'd1;
        tick();                 // DONE -> DRAIN
        obi_rvalid = 1'b1;
        tick();                 // DRAIN -> IDLE
        obi_rvalid = 1'b0;
    endtask

    initial begin
        int lat;
        int bad;
        bit saw_to;
        vec_t v;

        rst = 1'b1;
        reg_valid = 1'b0; reg_write = 1'b0; reg_addr = '0; reg_wdata = '0; reg_wstrb = '0;
        obi_gnt = 1'b0; obi_rvalid = 1'b0; obi_rdata = '0;
        z_valid = 1'b0; z_write = 1'b0; z_addr = '0; z_wdata = '0; z_wstrb = '0;
        z_gnt = 1'b0; z_rvalid = 1'b0; z_obi_rdata = '0;

        // write addr        wdata         wstrb gnt rv rdata         e_addr        e_be  e_rdata       err lat
        vecs[0] = '{1'b0, 32'h0000_1006, 32'h0,        4'h0, 2, 0, 32'hDEAD_BEEF, 32'h0000_1004, 4'hF, 32'hDEAD_BEEF, 1'b0, 6};
        vecs[1] = '{1'b1, 32'h0000_0020, 32'h1234_5678, 4'h3, 0, 0, 32'hCAFE_F00D, 32'h0000_0020, 4'h3, 32'h0,        1'b0, 4};
        vecs[2] = '{1'b0, 32'hFFFF_FFFF, 32'h0,        4'h0, 0, 3, 32'h0BAD_C0DE, 32'hFFFF_FFFC, 4'hF, 32'h0BAD_C0DE, 1'b0, 7};
        vecs[3] = '{1'b1, 32'h8000_0003, 32'hA5A5_A5A5, 4'h8, 1, 2, 32'h1111_2222, 32'h8000_0000, 4'h8, 32'h0,        1'b0, 7};
        vecs[4] = '{1'b0, 32'h0000_0004, 32'h0,        4'h0, 0, 0, 32'h1357_9BDF, 32'h0000_0004, 4'hF, 32'h1357_9BDF, 1'b0, 4};
        vecs[5] = '{1'b0, 32'h0000_0100, 32'h0,        4'h0, 0, 7, 32'h55AA_55AA, 32'h0000_0100, 4'hF, 32'h55AA_55AA, 1'b0, 11};
        vecs[6] = '{1'b1, 32'h0000_7FFE, 32'hFFFF_FFFF, 4'hF, 3, 6, 32'h7777_7777, 32'h0000_7FFC, 4'hF, 32'h0,        1'b0, 13};

        // ---- reset state
        repeat (3) tick();
        check("rst_req",    32'(obi_req),   32'd0);
        check("rst_ready",  32'(reg_ready), 32'd0);
        check("rst_error",  32'(reg_error), 32'd0);
        check("rst_rdata",  reg_rdata,      32'd0);
        check("rst_addr",   obi_addr,       32'd0);
        check("rst_be",     32'(obi_be),    32'd0);
        check("rst_to",     32'(timeout),   32'd0);
        check("rst_tcount", 32'(tcount),    32'd0);
        check("rst_z_req",  32'(z_req),     32'd0);
        rst = 1'b0;
        tick();

        // ---- table-driven transactions (vector 5 has rvalid in the expiry cycle)
        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // ---- watchdog expiry, then drain blocks new work
        reg_valid = 1'b1; reg_write = 1'b0; reg_addr = 32'h300; reg_wstrb = 4'h0;
        lat = 0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            obi_gnt = 1'b0;
            obi_rdata = 32'hBAD0_BAD0;
            if (reg_ready) begin
                lat = c;
                break;
            end
            if (c == 1) obi_gnt = 1'b1;
        end
        exp_tc = 8'd1;
        check("to_expiry_cycle", 32'(lat),       32'd10);
        check("to_error",        32'(reg_error), 32'd1);
        check("to_pulse",        32'(timeout),   32'd1);
        check("to_rdata",        reg_rdata,      32'd0);
        check("to_tcount",       32'(tcount),    32'(exp_tc));
        // New request held throughout the drain window.
        reg_addr = 32'h402;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (obi_req || reg_ready || timeout) bad++;
        end
        check("drain_blocks", 32'(bad), 32'd0);
        obi_rvalid = 1'b1;
        obi_rdata  = 32'hBAD0_BAD0;
        tick();
        obi_rvalid = 1'b0;
        check("drain_no_ready", 32'(reg_ready), 32'd0);
        check("drain_no_req",   32'(obi_req),   32'd0);
        v = '{1'b0, 32'h0000_0402, 32'h0, 4'h0, 0, 1, 32'hFEED_FACE, 32'h0000_0400, 4'hF, 32'hFEED_FACE, 1'b0, 5};
        run_txn(v, "post_drain");

        // ---- saturation of the timeout counter
        for (int i = 0; i < 300; i++) force_timeout();
        check("sat_tcount", 32'(tcount), 32'd255);

        // ---- reset in the middle of a request
        reg_valid = 1'b1; reg_write = 1'b1; reg_addr = 32'h1234; reg_wdata = 32'h99; reg_wstrb = 4'hF;
        tick();
        check("mrst_req_before", 32'(obi_req), 32'd1);
        rst = 1'b1;
        reg_valid = 1'b0;
        tick();
        check("mrst_req",    32'(obi_req),   32'd0);
        check("mrst_ready",  32'(reg_ready), 32'd0);
        check("mrst_error",  32'(reg_error), 32'd0);
        check("mrst_addr",   obi_addr,       32'd0);
        check("mrst_wdata",  obi_wdata,      32'd0);
        check("mrst_we",     32'(obi_we),    32'd0);
        check("mrst_tcount", 32'(tcount),    32'd0);
        rst = 1'b0;
        exp_tc = 8'd0;
        tick();
        v = '{1'b0, 32'h0000_0808, 32'h0, 4'h0, 1, 0, 32'h2468_ACE0, 32'h0000_0808, 4'hF, 32'h2468_ACE0, 1'b0, 5};
        run_txn(v, "post_rst");

        // ---- watchdog disabled: very slow response completes cleanly
        z_valid = 1'b1; z_write = 1'b0; z_addr = 32'h88;
        lat = 0;
        saw_to = 1'b0;
        for (int c = 1; c <= 1100; c++) begin
            tick();
            z_gnt = 1'b0;
            z_rvalid = 1'b0;
            z_obi_rdata = 32'hBAD0_BAD0;
            if (z_timeout) saw_to = 1'b1;
            if (z_ready) begin
                lat = c;
                break;
            end
            if (c == 1) z_gnt = 1'b1;
            if (c == 1002) begin
                z_rvalid = 1'b1;
                z_obi_rdata = 32'h600D_F00D;
            end
        end
        z_valid = 1'b0;
        check("nowd_ready_cycle", 32'(lat),      32'd1003);
        check("nowd_error",       32'(z_error),  32'd0);
        check("nowd_rdata",       z_rdata,       32'h600D_F00D);
        check("nowd_no_to",       32'(saw_to),   32'd0);
        check("nowd_tcount",      32'(z_tcount), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
